// File: rtl/weight_stream_sequencer_if.sv
// ============================================================================
// Module      : weight_stream_sequencer_if
// Description : Command, load-stream, weight-RAM and MAC-stream signals of the
//               weight stream sequencer, with controller/environment modports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface weight_stream_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              START;
    logic              MODE;
    logic [DATA_W-1:0] LD_DATA;
    logic              LD_VALID;
    logic              LD_READY;
    logic [ADDR_W-1:0] BRAM_ADDR;
    logic [DATA_W-1:0] BRAM_DI;
    logic              BRAM_EN;
    logic              BRAM_WE;
    logic [DATA_W-1:0] BRAM_DO;
    logic [DATA_W-1:0] W_DATA;
    logic              W_VALID;
    logic              W_LAST;
    logic              W_READY;
    logic              BUSY;
    logic              DONE;

    modport slave (
        input  START, MODE, LD_DATA, LD_VALID, BRAM_DO, W_READY,
        output LD_READY, BRAM_ADDR, BRAM_DI, BRAM_EN, BRAM_WE,
               W_DATA, W_VALID, W_LAST, BUSY, DONE
    );

    modport master (
        output START, MODE, LD_DATA, LD_VALID, BRAM_DO, W_READY,
        input  LD_READY, BRAM_ADDR, BRAM_DI, BRAM_EN, BRAM_WE,
               W_DATA, W_VALID, W_LAST, BUSY, DONE
    );
endinterface

`default_nettype wire

// File: rtl/weight_stream_sequencer.sv
// ============================================================================
// Module      : weight_stream_sequencer
// Description : Loads DEPTH weights into a negedge weight RAM and streams them
//               to the MAC through a 2-entry buffer. Optional running checksum
//               output enabled by macro WEIGHT_STREAM_CKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_stream_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 28
) (
    input  logic                     CLK,
    input  logic                     RST,
    weight_stream_sequencer_if.slave bus
`ifdef WEIGHT_STREAM_CKSUM_EN
    ,
    output logic [DATA_W-1:0]        CKSUM
`endif
);

    localparam int             CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  wr_cnt_q, rd_cnt_q, pop_cnt_q;
    logic              bram_en_q, bram_we_q;
    logic [ADDR_W-1:0] bram_addr_q;
    logic [DATA_W-1:0] bram_di_q;
    logic              rd_inflight_q;
    logic [DATA_W-1:0] buf0_q, buf1_q;
    logic [1:0]        buf_cnt_q;

    logic              start_acc;
    logic              ld_ready;
    logic              ld_hs;
    logic              w_valid;
    logic              pop;
    logic              last;
    logic [1:0]        occ;
    logic              room;
    logic              issue;

    assign start_acc = (state_q == ST_IDLE) && bus.START;
    assign ld_ready  = (state_q == ST_LOAD) && (wr_cnt_q < CNT_DEPTH);
    assign ld_hs     = ld_ready && bus.LD_VALID;
    assign w_valid   = (buf_cnt_q != 2'd0);
    assign pop       = w_valid && bus.W_READY;
    assign last      = w_valid && (pop_cnt_q == CNT_LAST);

    // Buffered words plus the read in flight must never exceed the two slots,
    // unless a pop frees one in the same cycle.
    assign occ   = buf_cnt_q + {1'b0, rd_inflight_q};
    assign room  = (occ < 2'd2) || ((occ == 2'd2) && pop);
    assign issue = (start_acc && !bus.MODE)
                || ((state_q == ST_FETCH) && (rd_cnt_q < CNT_DEPTH) && room);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d = bus.MODE ? ST_LOAD : ST_FETCH;
                end
            end
            ST_LOAD: begin
                if (wr_cnt_q == CNT_DEPTH) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                if ((rd_cnt_q == CNT_DEPTH) || (issue && (rd_cnt_q == CNT_LAST))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bram_en_q     <= 1'b0;
            bram_we_q     <= 1'b0;
            bram_addr_q   <= '0;
            bram_di_q     <= '0;
            rd_inflight_q <= 1'b0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            pop_cnt_q     <= '0;
            buf0_q        <= '0;
            buf1_q        <= '0;
            buf_cnt_q     <= 2'd0;
        end else begin
            bram_en_q     <= ld_hs || issue;
            bram_we_q     <= ld_hs;
            rd_inflight_q <= issue;
            if (ld_hs) begin
                bram_addr_q <= wr_cnt_q[ADDR_W-1:0];
                bram_di_q   <= bus.LD_DATA;
            end else if (issue) begin
                // rd_cnt_q still holds the previous run's count on the start cycle
                bram_addr_q <= start_acc ? '0 : rd_cnt_q[ADDR_W-1:0];
            end

            if (start_acc) begin
                wr_cnt_q  <= '0;
                pop_cnt_q <= '0;
                rd_cnt_q  <= issue ? CNT_ONE : '0;
            end else begin
                if (ld_hs) wr_cnt_q <= wr_cnt_q + CNT_ONE;
                if (issue) rd_cnt_q <= rd_cnt_q + CNT_ONE;
                if (pop)   pop_cnt_q <= pop_cnt_q + CNT_ONE;
            end

            case ({rd_inflight_q, pop})
                2'b10: begin
                    if (buf_cnt_q == 2'd0) buf0_q <= bus.BRAM_DO;
                    else                   buf1_q <= bus.BRAM_DO;
                    buf_cnt_q <= buf_cnt_q + 2'd1;
                end
                2'b01: begin
                    buf0_q    <= buf1_q;
                    buf_cnt_q <= buf_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt_q == 2'd1) begin
                        buf0_q <= bus.BRAM_DO;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= bus.BRAM_DO;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WEIGHT_STREAM_CKSUM_EN
    logic [DATA_W-1:0] cksum_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cksum_q <= '0;
        end else if (start_acc) begin
            cksum_q <= '0;
        end else if (ld_hs) begin
            cksum_q <= cksum_q + bus.LD_DATA;
        end else if (pop) begin
            cksum_q <= cksum_q + buf0_q;
        end
    end

    assign CKSUM = cksum_q;
`else
    // Checksum build option disabled: no accumulator present.
`endif

    assign bus.LD_READY  = ld_ready;
    assign bus.BRAM_EN   = bram_en_q;
    assign bus.BRAM_WE   = bram_we_q;
    assign bus.BRAM_ADDR = bram_addr_q;
    assign bus.BRAM_DI   = bram_di_q;
    assign bus.W_DATA    = buf0_q;
    assign bus.W_VALID   = w_valid;
    assign bus.W_LAST    = last;
    assign bus.BUSY      = (state_q != ST_IDLE);
    assign bus.DONE      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_weight_stream_sequencer.sv
// ============================================================================
// Module      : tb_weight_stream_sequencer
// Description : Directed/randomized bench for weight_stream_sequencer with a
//               behavioural RAM and expected-contents model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_weight_stream_sequencer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 28;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    weight_stream_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
`ifdef WEIGHT_STREAM_CKSUM_EN
    logic [DATA_W-1:0] cksum;
`endif

    weight_stream_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .RST   (rst),
        .bus   (bus)
`ifdef WEIGHT_STREAM_CKSUM_EN
        ,
        .CKSUM (cksum)
`endif
    );

    // Negedge weight RAM
    logic [DATA_W-1:0] ram [0:31];
    always @(negedge clk) begin
        if (bus.BRAM_EN) begin
            if (bus.BRAM_WE) ram[bus.BRAM_ADDR] <= bus.BRAM_DI;
            else             bus.BRAM_DO <= ram[bus.BRAM_ADDR];
        end
    end

    // Per-cycle event log, indexed by the cycle that just ended
    int cyc = 0;
    int addr_bad = 0;
    int stall_bad = 0;
    int en_cnt = 0;
    int wr_addr_q[$], wr_data_q[$], wr_cyc_q[$];
    int pop_data_q[$], pop_last_q[$], pop_cyc_q[$];
    int done_cyc_q[$], last_cyc_q[$];
    logic prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.BRAM_EN) begin
                en_cnt <= en_cnt + 1;
                if (int'(bus.BRAM_ADDR) >= DEPTH) addr_bad <= addr_bad + 1;
            end
            if (bus.BRAM_EN && bus.BRAM_WE) begin
                wr_addr_q.push_back(int'(bus.BRAM_ADDR));
                wr_data_q.push_back(int'(bus.BRAM_DI));
                wr_cyc_q.push_back(cyc);
            end
            if (bus.W_VALID && bus.W_READY) begin
                pop_data_q.push_back(int'(bus.W_DATA));
                pop_last_q.push_back(int'(bus.W_LAST));
                pop_cyc_q.push_back(cyc);
            end
            if (bus.W_LAST) last_cyc_q.push_back(cyc);
            if (bus.DONE)   done_cyc_q.push_back(cyc);
            if (prev_stall && !(bus.W_VALID && (bus.W_DATA == prev_data))) stall_bad <= stall_bad + 1;
            prev_stall <= bus.W_VALID && !bus.W_READY;
            prev_data  <= bus.W_DATA;
        end else begin
            prev_stall <= 1'b0;
        end
        cyc <= cyc + 1;
    end

    int n_pass = 0;
    int n_total = 0;
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] words   [DEPTH];

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int mode, input int t);
        case (mode)
            0:       return 1'b1;
            1:       return ((t % 4) == 0) || ((t % 4) == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    function automatic int ref_sum();
        int s = 0;
        for (int k = 0; k < DEPTH; k++) s = (s + int'(ref_mem[k])) % 65536;
        return s;
    endfunction

    // LOAD with 'gap' idle cycles after each accepted word; stops after
    // abort_at handshakes when abort_at >= 0.
    task automatic run_load(input int gap, input int abort_at, output int s);
        int i = 0;
        int g = 0;
        int db;
        db = done_cyc_q.size();
        tick();
        s = cyc;
        bus.START = 1'b1; bus.MODE = 1'b1; bus.LD_VALID = 1'b0;
        tick();
        bus.START = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (done_cyc_q.size() != db) break;
            if (i < DEPTH && i != abort_at && g == 0) begin
                bus.LD_VALID = 1'b1;
                bus.LD_DATA  = words[i];
            end else begin
                bus.LD_VALID = 1'b0;
                if (g > 0) g--;
            end
            if (bus.LD_VALID && bus.LD_READY) begin
                i++;
                g = gap;
            end
            tick();
            if (abort_at >= 0 && i == abort_at) break;
        end
        bus.LD_VALID = 1'b0;
    endtask

    task automatic run_fetch(input int mode, input bit inject, output int s, output logic busy_at_done);
        busy_at_done = 1'b1;
        tick();
        s = cyc;
        bus.START = 1'b1; bus.MODE = 1'b0; bus.W_READY = rdy(mode, 0);
        for (int t = 1; t < 400; t++) begin
            tick();
            bus.START    = inject && (t == 10);
            bus.MODE     = bus.START;
            bus.LD_VALID = bus.START;
            bus.LD_DATA  = 16'hBEEF;
            bus.W_READY  = rdy(mode, t);
            if (bus.DONE) begin
                busy_at_done = bus.BUSY;
                break;
            end
        end
        bus.START = 1'b0; bus.MODE = 1'b0; bus.LD_VALID = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int wb, input int n_exp);
        int n = wr_addr_q.size() - wb;
        int bad = 0;
        check({tag, "_wr_count"}, n, n_exp);
        for (int k = 0; k < n && k < DEPTH; k++)
            if (wr_addr_q[wb+k] != k || wr_data_q[wb+k] != int'(words[k])) bad++;
        check({tag, "_wr_addr_data"}, bad, 0);
    endtask

    task automatic check_stream(input string tag, input int pb, input int db, input int ab, input int sb);
        int n = pop_data_q.size() - pb;
        int bad = 0;
        int lastn = 0;
        check({tag, "_pop_count"}, n, DEPTH);
        for (int k = 0; k < n; k++) begin
            if (k >= DEPTH || pop_data_q[pb+k] != int'(ref_mem[k])) bad++;
            lastn += pop_last_q[pb+k];
        end
        check({tag, "_order"}, bad, 0);
        check({tag, "_last_count"}, lastn, 1);
        check({tag, "_last_pos"}, (n > 0) ? pop_last_q[pb+n-1] : 0, 1);
        check({tag, "_done_count"}, done_cyc_q.size() - db, 1);
        check({tag, "_addr_range"}, addr_bad - ab, 0);
        check({tag, "_stall_hold"}, stall_bad - sb, 0);
    endtask

    initial begin
        int s, wb, pb, db, lb, ab, sb, eb, bad;
        logic bad_busy;
        bus.START = 1'b0; bus.MODE = 1'b0; bus.LD_DATA = '0;
        bus.LD_VALID = 1'b0; bus.W_READY = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check("reset_ctrl", int'({bus.LD_READY, bus.BRAM_EN, bus.BRAM_WE, bus.W_VALID,
                                  bus.W_LAST, bus.BUSY, bus.DONE, bus.BRAM_ADDR}), 0);
        check("reset_data", int'({bus.W_DATA, bus.BRAM_DI}), 0);
        rst = 1'b0;
        tick();

        // LOAD 1..28 back to back
        for (int k = 0; k < DEPTH; k++) words[k] = DATA_W'(k + 1);
        wb = wr_addr_q.size(); db = done_cyc_q.size();
        run_load(0, -1, s);
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = words[k];
        tick();
        check_writes("load1", wb, DEPTH);
        check("load1_first_wr_cyc", (wr_cyc_q.size() > wb) ? wr_cyc_q[wb] - s : -1, 2);
        check("load1_wr_span", (wr_cyc_q.size() >= wb + DEPTH) ? wr_cyc_q[wb+DEPTH-1] - wr_cyc_q[wb] : -1, DEPTH - 1);
        check("load1_done_count", done_cyc_q.size() - db, 1);
        check("load1_done_cyc", (done_cyc_q.size() > db && wr_cyc_q.size() >= wb + DEPTH)
                                ? done_cyc_q[db] - wr_cyc_q[wb+DEPTH-1] : -1, 1);
        bad = 0;
        for (int k = 0; k < DEPTH; k++) if (ram[k] !== ref_mem[k]) bad++;
        check("load1_ram", bad, 0);
`ifdef WEIGHT_STREAM_CKSUM_EN
        check("load1_cksum", int'(cksum), 32'h0196);
`endif

        // FETCH with W_READY held high: exact cycle timing
        pb = pop_data_q.size(); db = done_cyc_q.size(); lb = last_cyc_q.size();
        ab = addr_bad; sb = stall_bad;
        run_fetch(0, 1'b0, s, bad_busy);
        check("fetch1_busy_at_done", int'(bad_busy), 0);
        tick();
        check_stream("fetch1", pb, db, ab, sb);
        bad = 0;
        for (int k = 0; k < pop_cyc_q.size() - pb; k++) if (pop_cyc_q[pb+k] - s != 2 + k) bad++;
        check("fetch1_pop_cycles", bad, 0);
        check("fetch1_last_cyc", (last_cyc_q.size() - lb == 1) ? last_cyc_q[lb] - s : -1, 29);
        check("fetch1_done_cyc", (done_cyc_q.size() > db) ? done_cyc_q[db] - s : -1, 30);
`ifdef WEIGHT_STREAM_CKSUM_EN
        check("fetch1_cksum", int'(cksum), ref_sum());
`endif

        // FETCH with W_READY pattern 1,0,0,1
        pb = pop_data_q.size(); db = done_cyc_q.size(); ab = addr_bad; sb = stall_bad;
        run_fetch(1, 1'b0, s, bad_busy);
        tick();
        check_stream("fetch_bp", pb, db, ab, sb);

        // START with MODE=1 during FETCH must be ignored
        pb = pop_data_q.size(); db = done_cyc_q.size(); ab = addr_bad; sb = stall_bad;
        wb = wr_addr_q.size();
        run_fetch(0, 1'b1, s, bad_busy);
        tick();
        check_stream("fetch_inj", pb, db, ab, sb);
        check("fetch_inj_no_write", wr_addr_q.size() - wb, 0);
`ifdef WEIGHT_STREAM_CKSUM_EN
        check("fetch_inj_cksum", int'(cksum), ref_sum());
`endif

        // Random words with 3-cycle LD_VALID gaps
        for (int k = 0; k < DEPTH; k++) words[k] = DATA_W'($urandom);
        wb = wr_addr_q.size(); eb = en_cnt;
        run_load(3, -1, s);
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = words[k];
        tick();
        check_writes("load_gap", wb, DEPTH);
        check("load_gap_en_cycles", en_cnt - eb, DEPTH);
        bad = 0;
        for (int k = 1; k < wr_cyc_q.size() - wb; k++) if (wr_cyc_q[wb+k] - wr_cyc_q[wb+k-1] != 4) bad++;
        check("load_gap_spacing", bad, 0);
        pb = pop_data_q.size(); db = done_cyc_q.size(); ab = addr_bad; sb = stall_bad;
        run_fetch(2, 1'b0, s, bad_busy);
        tick();
        check_stream("fetch_rand1", pb, db, ab, sb);

        // Reset during LOAD after 10 writes
        for (int k = 0; k < DEPTH; k++) words[k] = DATA_W'($urandom);
        wb = wr_addr_q.size(); db = done_cyc_q.size();
        run_load(0, 10, s);
        tick();
        rst = 1'b1;
        tick();
        check("abort_ctrl", int'({bus.LD_READY, bus.BRAM_EN, bus.BRAM_WE, bus.W_VALID,
                                  bus.W_LAST, bus.BUSY, bus.DONE, bus.BRAM_ADDR}), 0);
        check("abort_data", int'({bus.W_DATA, bus.BRAM_DI}), 0);
`ifdef WEIGHT_STREAM_CKSUM_EN
        check("abort_cksum", int'(cksum), 0);
`endif
        rst = 1'b0;
        tick();
        check("abort_wr_count", wr_addr_q.size() - wb, 10);
        check("abort_no_done", done_cyc_q.size() - db, 0);
        for (int k = 0; k < 10; k++) ref_mem[k] = words[k];
        pb = pop_data_q.size(); db = done_cyc_q.size(); ab = addr_bad; sb = stall_bad;
        run_fetch(2, 1'b0, s, bad_busy);
        tick();
        check_stream("fetch_after_abort", pb, db, ab, sb);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
